// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and stream framing constants for the boot loader.
// Rev 1.0
`default_nettype none

package imem_loader_pkg;

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

endpackage

`default_nettype wire

// File: rtl/loader_word_pack.sv
// loader_word_pack: packs a byte stream big-endian into 32-bit words, one-cycle registered word strobe.
// Rev 1.0
`default_nettype none

module loader_word_pack
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_last_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] shift_q, shift_d;
  logic        valid_q;

  assign word_last_o = byte_valid_i & ~clear_i & (idx_q == LAST_IDX);

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (clear_i) begin
      idx_d   = 2'd0;
      shift_d = 32'd0;
    end else if (byte_valid_i) begin
      shift_d = {shift_q[23:0], byte_i};
      idx_d   = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q   <= 2'd0;
      shift_q <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
      valid_q <= word_last_o;
    end
  end

  // The shift register holds the completed word for exactly the strobe cycle.
  assign word_valid_o = valid_q;
  assign word_o       = shift_q;

endmodule

`default_nettype wire

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a length-prefixed byte image into instruction memory, then releases the core.
// Optional trailing checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.  Rev 1.0
`default_nettype none

module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam logic [16:0]   MAX_WORDS = 17'(1) << ADDR_W;
  localparam logic [ADDR_W:0] ONE_W   = (ADDR_W + 1)'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e AFTER_PAYLOAD = CSUM;
`else
  localparam state_e AFTER_PAYLOAD = DONE;
`endif

  state_e            state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [ADDR_W:0]   last_q, last_d;
  logic [ADDR_W:0]   widx_q, widx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rx_ready_q, done_q, error_q, cpu_reset_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  logic        w_hs, w_byte_valid, w_word_last;
  logic [15:0] w_len;

  assign w_hs         = rx_valid & rx_ready_q;
  assign w_byte_valid = w_hs & (state_q == DATA);
  assign w_len        = {len_hi_q, rx_data};

  loader_word_pack u_pack (
    .clock        (clock),
    .reset        (reset),
    .clear_i      (state_q != DATA),
    .byte_valid_i (w_byte_valid),
    .byte_i       (rx_data),
    .word_last_o  (w_word_last),
    .word_valid_o (imem_we),
    .word_o       (imem_wdata)
  );

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    last_d   = last_q;
    widx_d   = widx_q;
    addr_d   = addr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    case (state_q)
      LEN_HI: begin
        if (w_hs) begin
          len_hi_d = rx_data;
          state_d  = LEN_LO;
        end
      end
      LEN_LO: begin
        if (w_hs) begin
          last_d = w_len[ADDR_W:0] - ONE_W;
          if ({1'b0, w_len} > MAX_WORDS)  state_d = ERR;
          else if (w_len == 16'd0)        state_d = AFTER_PAYLOAD;
          else                            state_d = DATA;
        end
      end
      DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (w_byte_valid) sum_d = sum_q + rx_data;
`endif
        if (w_word_last) begin
          addr_d = widx_q[ADDR_W-1:0];
          widx_d = widx_q + ONE_W;
          if (widx_q == last_q) state_d = AFTER_PAYLOAD;
        end
      end
      CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (w_hs) state_d = (rx_data == sum_q) ? DONE : ERR;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= LEN_HI;
      len_hi_q    <= 8'd0;
      last_q      <= '0;
      widx_q      <= '0;
      addr_q      <= '0;
      rx_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_reset_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      last_q      <= last_d;
      widx_q      <= widx_d;
      addr_q      <= addr_d;
      rx_ready_q  <= (state_d != DONE) && (state_d != ERR);
      done_q      <= (state_d == DONE);
      error_q     <= (state_d == ERR);
      // Lagging done by one edge lets the final word's write retire first.
      cpu_reset_q <= done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign rx_ready  = rx_ready_q;
  assign imem_addr = addr_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: scoreboard bench for imem_boot_loader (follows IMEM_LOADER_CHECKSUM_EN).
// Rev 1.0
`default_nettype none

module tb_imem_boot_loader;

  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          rx_ready, imem_we, cpu_reset, done, error;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t        sb[$];
  wr_t        mon_e;
  logic [7:0] stream[$];
  int         errors = 0;
  int         checks = 0;
  int         writes_seen = 0;

  imem_boot_loader #(.ADDR_W(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset && imem_we) begin
      writes_seen++;
      if (sb.size() == 0) begin
        check("write_with_empty_sb", 32'(imem_we), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("imem_addr", 32'(imem_addr), 32'(mon_e.addr));
        check("imem_wdata", imem_wdata, mon_e.data);
      end
    end
    if (done && error) check("done_error_both", 32'(error), 32'd0);
  end

  task automatic idle(input int k);
    rx_valid = 1'b0;
    repeat (k) begin
      rx_data = 8'($urandom);
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clock);
    while (!rx_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!rx_ready) begin
      check("ready_timeout", 32'(rx_ready), 32'd1);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Model: big-endian packing of payload bytes into words at consecutive addresses.
  task automatic send_stream(input bit stall);
    int          n = 0;
    logic [31:0] w = 32'd0;
    for (int i = 0; i < stream.size(); i++) begin
      if (stall) begin
        if (i % 2 == 1) idle(1);
        if (i == 4)     idle(5);
      end
      if (i == 1) n = {16'd0, stream[0], stream[1]};
      if (i >= 2 && n <= (1 << AW) && i < 2 + 4 * n) begin
        w = {w[23:0], stream[i]};
        if ((i - 2) % 4 == 3) sb.push_back('{addr: AW'((i - 2) / 4), data: w});
      end
      send_byte(stream[i]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    check("rst_rx_ready",   32'(rx_ready),   32'd0);
    check("rst_imem_we",    32'(imem_we),    32'd0);
    check("rst_imem_addr",  32'(imem_addr),  32'd0);
    check("rst_imem_wdata", imem_wdata,      32'd0);
    check("rst_cpu_reset",  32'(cpu_reset),  32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_error",      32'(error),      32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    writes_seen = 0;
    @(posedge clock);
    #1;
    check("ready_after_reset", 32'(rx_ready), 32'd1);
  endtask

  task automatic end_check(input bit done_e, input bit err_e, input int writes_e);
    check("done",          32'(done),      32'(done_e));
    check("error",         32'(error),     32'(err_e));
    check("rx_ready_end",  32'(rx_ready),  32'd0);
    check("cpu_reset_lag", 32'(cpu_reset), 32'd0);
    @(posedge clock);
    #1;
    check("cpu_reset",     32'(cpu_reset), 32'(done_e));
    repeat (3) @(posedge clock);
    #1;
    check("cpu_reset_hold", 32'(cpu_reset), 32'(done_e));
    check("done_sticky",    32'(done),      32'(done_e));
    check("error_sticky",   32'(error),     32'(err_e));
    check("write_count",    32'(writes_seen), 32'(writes_e));
    check("sb_empty",       32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] sum;
    do_reset();

    // Basic two-word load
    stream = {8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h0A};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'h52);
`endif
    send_stream(1'b0);
    end_check(1'b1, 1'b0, 2);

    // Same image with stalls
    do_reset();
    send_stream(1'b1);
    end_check(1'b1, 1'b0, 2);

    // Empty image
    do_reset();
    stream = {8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'h00);
`endif
    send_stream(1'b0);
    end_check(1'b1, 1'b0, 0);

    // Oversize (300 words)
    do_reset();
    stream = {8'h01, 8'h2C};
    send_stream(1'b0);
    end_check(1'b0, 1'b1, 0);

    // One past the maximum
    do_reset();
    stream = {8'h01, 8'h01};
    send_stream(1'b0);
    end_check(1'b0, 1'b1, 0);

    // Exactly the maximum image size
    do_reset();
    stream = {8'h01, 8'h00};
    sum = 8'd0;
    for (int i = 0; i < 4 * (1 << AW); i++) begin
      stream.push_back(8'($urandom));
      sum = sum + stream[stream.size() - 1];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(sum);
`endif
    send_stream(1'b0);
    end_check(1'b1, 1'b0, 1 << AW);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad then good checksum
    do_reset();
    stream = {8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
    send_stream(1'b0);
    end_check(1'b0, 1'b1, 1);
    do_reset();
    stream = {8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    send_stream(1'b0);
    end_check(1'b1, 1'b0, 1);
`endif

    // Reset after two payload bytes of word 1, then a fresh load
    do_reset();
    stream = {8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_stream(1'b0);
    check("midword_writes", 32'(writes_seen), 32'd1);
    do_reset();
    check("midword_sb_empty", 32'(sb.size()), 32'd0);
    stream = {8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'h0E);
`endif
    send_stream(1'b0);
    end_check(1'b1, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
